// File: rtl/kbd_pkg.sv
// Shared state encoding, port addresses, status bit positions and command codes
// for the keyboard output-buffer controller.
package kbd_pkg;

  typedef enum logic [1:0] {
    KBD_IDLE,
    KBD_LOAD,
    KBD_FULL,
    KBD_GAP
  } kbd_state_t;

  localparam logic [15:0] KBD_PORT_DATA = 16'h0060;
  localparam logic [15:0] KBD_PORT_CMD  = 16'h0064;

  localparam int STAT_OBF = 0;
  localparam int STAT_OVR = 1;
  localparam int STAT_EN  = 4;

  localparam logic [7:0] CMD_KBD_DISABLE = 8'hAD;
  localparam logic [7:0] CMD_KBD_ENABLE  = 8'hAE;
  localparam logic [7:0] CMD_FIFO_FLUSH  = 8'hC0;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT0  = 8'hE0;
  localparam logic [7:0] PS2_EXT1  = 8'hE1;

endpackage

// File: rtl/kbd_at2xt.sv
// Combinational AT scancode set 2 -> XT set 1 table; unlisted codes pass through.
// Only compiled when KBD_XT_TRANSLATE_EN is defined, since nothing else uses it.
`ifdef KBD_XT_TRANSLATE_EN
module kbd_at2xt (
  input  logic [7:0] at_code,
  output logic [7:0] xt_code
);

  always_comb begin
    xt_code = at_code;
    case (at_code)
      8'h76: xt_code = 8'h01;  8'h16: xt_code = 8'h02;  8'h1E: xt_code = 8'h03;
      8'h26: xt_code = 8'h04;  8'h25: xt_code = 8'h05;  8'h2E: xt_code = 8'h06;
      8'h36: xt_code = 8'h07;  8'h3D: xt_code = 8'h08;  8'h3E: xt_code = 8'h09;
      8'h46: xt_code = 8'h0A;  8'h45: xt_code = 8'h0B;  8'h4E: xt_code = 8'h0C;
      8'h55: xt_code = 8'h0D;  8'h66: xt_code = 8'h0E;  8'h0D: xt_code = 8'h0F;
      8'h15: xt_code = 8'h10;  8'h1D: xt_code = 8'h11;  8'h24: xt_code = 8'h12;
      8'h2D: xt_code = 8'h13;  8'h2C: xt_code = 8'h14;  8'h35: xt_code = 8'h15;
      8'h3C: xt_code = 8'h16;  8'h43: xt_code = 8'h17;  8'h44: xt_code = 8'h18;
      8'h4D: xt_code = 8'h19;  8'h54: xt_code = 8'h1A;  8'h5B: xt_code = 8'h1B;
      8'h5A: xt_code = 8'h1C;  8'h14: xt_code = 8'h1D;  8'h1C: xt_code = 8'h1E;
      8'h1B: xt_code = 8'h1F;  8'h23: xt_code = 8'h20;  8'h2B: xt_code = 8'h21;
      8'h34: xt_code = 8'h22;  8'h33: xt_code = 8'h23;  8'h3B: xt_code = 8'h24;
      8'h42: xt_code = 8'h25;  8'h4B: xt_code = 8'h26;  8'h4C: xt_code = 8'h27;
      8'h52: xt_code = 8'h28;  8'h0E: xt_code = 8'h29;  8'h12: xt_code = 8'h2A;
      8'h5D: xt_code = 8'h2B;  8'h1A: xt_code = 8'h2C;  8'h22: xt_code = 8'h2D;
      8'h21: xt_code = 8'h2E;  8'h2A: xt_code = 8'h2F;  8'h32: xt_code = 8'h30;
      8'h31: xt_code = 8'h31;  8'h3A: xt_code = 8'h32;  8'h41: xt_code = 8'h33;
      8'h49: xt_code = 8'h34;  8'h4A: xt_code = 8'h35;  8'h59: xt_code = 8'h36;
      8'h7C: xt_code = 8'h37;  8'h11: xt_code = 8'h38;  8'h29: xt_code = 8'h39;
      8'h58: xt_code = 8'h3A;  8'h05: xt_code = 8'h3B;  8'h06: xt_code = 8'h3C;
      8'h04: xt_code = 8'h3D;  8'h0C: xt_code = 8'h3E;  8'h03: xt_code = 8'h3F;
      8'h0B: xt_code = 8'h40;  8'h83: xt_code = 8'h41;  8'h0A: xt_code = 8'h42;
      8'h01: xt_code = 8'h43;  8'h09: xt_code = 8'h44;  8'h77: xt_code = 8'h45;
      8'h7E: xt_code = 8'h46;  8'h6C: xt_code = 8'h47;  8'h75: xt_code = 8'h48;
      8'h7D: xt_code = 8'h49;  8'h7B: xt_code = 8'h4A;  8'h6B: xt_code = 8'h4B;
      8'h73: xt_code = 8'h4C;  8'h74: xt_code = 8'h4D;  8'h79: xt_code = 8'h4E;
      8'h69: xt_code = 8'h4F;  8'h72: xt_code = 8'h50;  8'h7A: xt_code = 8'h51;
      8'h70: xt_code = 8'h52;  8'h71: xt_code = 8'h53;  8'h78: xt_code = 8'h57;
      8'h07: xt_code = 8'h58;
      default: xt_code = at_code;
    endcase
  end

endmodule
`endif

// File: rtl/kbd_fifo_ctrl.sv
// Scancode FIFO + 8042-style output buffer/IRQ1; strobe-to-OBF 2 clocks; KBD_XT_TRANSLATE_EN adds set2->set1.
// No backpressure towards PS/2: a push into a full FIFO is dropped and sets sticky OVR.
module kbd_fifo_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clock50,
  input  logic        reset,
  input  logic [7:0]  ps2_data,
  input  logic        ps2_data_clk,
  input  logic [15:0] port_addr,
  input  logic [15:0] port_out,
  input  logic        port_clk,
  input  logic        port_read,
  output logic [7:0]  kbd_data,
  output logic [7:0]  kbd_status,
  output logic        irq1
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  kbd_state_t     state, state_nxt;
  logic [GW-1:0]  gap_cnt;
  logic           read_q, wr_q;
  logic           read_fall, wr_fall;
  logic           rd_data, rd_status, wr_cmd, flush;
  logic           en, ovr, obf, load_buf;
  logic           push_req, do_push, do_pop, overflow;
  logic [7:0]     push_dat;
  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           fifo_empty, fifo_full;
  logic           unused_port_hi;

  assign unused_port_hi = ^port_out[15:8];

  always_ff @(posedge clock50) begin
    if (reset) begin
      read_q <= 1'b0;
      wr_q   <= 1'b0;
    end else begin
      read_q <= port_read;
      wr_q   <= port_clk;
    end
  end

  assign read_fall = read_q & ~port_read;
  assign wr_fall   = wr_q & ~port_clk;
  assign rd_data   = read_fall && (port_addr == KBD_PORT_DATA);
  assign rd_status = read_fall && (port_addr == KBD_PORT_CMD);
  assign wr_cmd    = wr_fall && (port_addr == KBD_PORT_CMD);
  assign flush     = wr_cmd && (port_out[7:0] == CMD_FIFO_FLUSH);

`ifdef KBD_XT_TRANSLATE_EN
  logic       brk;
  logic [7:0] xt_code;

  kbd_at2xt u_at2xt (
    .at_code (ps2_data),
    .xt_code (xt_code)
  );

  // E0/E1 prefixes bypass the table and leave a pending break flag for the code that follows.
  always_comb begin
    push_req = 1'b0;
    push_dat = xt_code;
    if (ps2_data_clk && en && ps2_data != PS2_BREAK) begin
      push_req = 1'b1;
      if (ps2_data == PS2_EXT0 || ps2_data == PS2_EXT1)
        push_dat = ps2_data;
      else
        push_dat = xt_code | {brk, 7'b0};
    end
  end

  always_ff @(posedge clock50) begin
    if (reset)
      brk <= 1'b0;
    else if (ps2_data_clk) begin
      if (!en)
        brk <= 1'b0;
      else if (ps2_data == PS2_BREAK)
        brk <= 1'b1;
      else if (ps2_data != PS2_EXT0 && ps2_data != PS2_EXT1)
        brk <= 1'b0;
    end
  end
`else
  assign push_req = ps2_data_clk & en;
  assign push_dat = ps2_data;
`endif

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign do_pop     = load_buf & ~fifo_empty;
  assign do_push    = push_req & ~flush & (~fifo_full | do_pop);
  assign overflow   = push_req & ~flush & fifo_full & ~do_pop;

  always_ff @(posedge clock50) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock50) begin
    if (do_push) fifo_mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      kbd_data <= 8'h00;
      en       <= 1'b1;
      ovr      <= 1'b0;
    end else begin
      if (do_pop) kbd_data <= fifo_mem[rd_ptr];
      if (wr_cmd && port_out[7:0] == CMD_KBD_DISABLE) en <= 1'b0;
      if (wr_cmd && port_out[7:0] == CMD_KBD_ENABLE)  en <= 1'b1;
      if (overflow)
        ovr <= 1'b1;
      else if (flush || rd_status)
        ovr <= 1'b0;
    end
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      state   <= KBD_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= (state == KBD_GAP) ? gap_cnt + GW'(1) : '0;
    end
  end

  // A flush in IDLE must not start a load of an entry that is being discarded.
  always_comb begin
    state_nxt = state;
    unique case (state)
      KBD_IDLE: if (!fifo_empty && !flush) state_nxt = KBD_LOAD;
      KBD_LOAD: state_nxt = KBD_FULL;
      KBD_FULL: if (rd_data) state_nxt = KBD_GAP;
      KBD_GAP:  if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = KBD_IDLE;
      default:  state_nxt = KBD_IDLE;
    endcase
  end

  always_comb begin
    obf      = 1'b0;
    load_buf = 1'b0;
    case (state)
      KBD_LOAD: load_buf = 1'b1;
      KBD_FULL: obf = 1'b1;
      default: ;
    endcase
  end

  assign irq1 = obf;

  always_comb begin
    kbd_status           = 8'h00;
    kbd_status[STAT_OBF] = obf;
    kbd_status[STAT_OVR] = ovr;
    kbd_status[STAT_EN]  = en;
  end

endmodule

// File: tb/tb_kbd_fifo_ctrl.sv
// Randomized and directed bench for kbd_fifo_ctrl against a byte-stream reference model.
`timescale 1ns/1ps
module tb_kbd_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int GAP   = 4;

  logic        clock50 = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ps2_data = 8'h00;
  logic        ps2_data_clk = 1'b0;
  logic [15:0] port_addr = 16'h0000;
  logic [15:0] port_out = 16'h0000;
  logic        port_clk = 1'b0;
  logic        port_read = 1'b0;
  logic [7:0]  kbd_data;
  logic [7:0]  kbd_status;
  logic        irq1;

  always #5 clock50 = ~clock50;

  kbd_fifo_ctrl #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clock50      (clock50),
    .reset        (reset),
    .ps2_data     (ps2_data),
    .ps2_data_clk (ps2_data_clk),
    .port_addr    (port_addr),
    .port_out     (port_out),
    .port_clk     (port_clk),
    .port_read    (port_read),
    .kbd_data     (kbd_data),
    .kbd_status   (kbd_status),
    .irq1         (irq1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bytes still owed to the CPU (output buffer + FIFO), in order.
  logic [7:0] pend[$];
  logic       en_m = 1'b1;
  logic       drop_m = 1'b0;
  logic [7:0] last_m = 8'h00;
`ifdef KBD_XT_TRANSLATE_EN
  logic       brk_m = 1'b0;
`endif
  logic [7:0] pool [10] = '{8'h1C, 8'h1B, 8'h23, 8'h16, 8'h29, 8'h5A, 8'h70, 8'h3F, 8'hE0, 8'hF0};

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xlat(input logic [7:0] b);
`ifdef KBD_XT_TRANSLATE_EN
    case (b)
      8'h1C: return 8'h1E;
      8'h1B: return 8'h1F;
      8'h23: return 8'h20;
      8'h16: return 8'h02;
      8'h29: return 8'h39;
      8'h5A: return 8'h1C;
      8'h70: return 8'h52;
      default: return b;
    endcase
`else
    return b;
`endif
  endfunction

  function automatic logic [7:0] status_m();
    return {3'b000, en_m, 2'b00, drop_m, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clock50);
    #1;
  endtask

  task automatic model_push(input logic [7:0] v);
    if (pend.size() < DEPTH + 1) pend.push_back(v);
    else drop_m = 1'b1;
  endtask

  task automatic drive_ps2(input logic [7:0] b);
    ps2_data = b;
    ps2_data_clk = 1'b1;
    tick();
    ps2_data_clk = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive_ps2(b);
`ifdef KBD_XT_TRANSLATE_EN
    if (!en_m) brk_m = 1'b0;
    else if (b == 8'hF0) brk_m = 1'b1;
    else if (b == 8'hE0 || b == 8'hE1) model_push(b);
    else begin
      model_push(xlat(b) | {brk_m, 7'b0});
      brk_m = 1'b0;
    end
`else
    if (en_m) model_push(b);
`endif
  endtask

  task automatic port_rd(input logic [15:0] a, output logic [7:0] v);
    port_addr = a;
    port_read = 1'b1;
    tick();
    v = (a == 16'h0060) ? kbd_data : kbd_status;
    port_read = 1'b0;
    tick();
  endtask

  task automatic port_wr(input logic [15:0] a, input logic [7:0] d);
    port_addr = a;
    port_out = {8'h00, d};
    port_clk = 1'b1;
    tick();
    port_clk = 1'b0;
    tick();
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [7:0] rv;
    int n = 0;
    while (!irq1 && n < 60) begin
      tick();
      n++;
    end
    check_val({tag, "_irq"}, irq1, 1);
    check_val({tag, "_obf"}, kbd_status[0], 1);
    port_rd(16'h0060, rv);
    check_val(tag, rv, exp);
    last_m = exp;
  endtask

  task automatic drain();
    while (pend.size() > 0) expect_byte("rx_byte", pend.pop_front());
    repeat (GAP + 4) tick();
    check_val("idle_irq", irq1, 0);
    check_val("idle_status", kbd_status, status_m());
  endtask

  task automatic model_reset();
    pend.delete();
    en_m = 1'b1;
    drop_m = 1'b0;
    last_m = 8'h00;
`ifdef KBD_XT_TRANSLATE_EN
    brk_m = 1'b0;
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rv;

    repeat (2) tick();
    check_val("rst_data", kbd_data, 8'h00);
    check_val("rst_status", kbd_status, 8'h10);
    check_val("rst_irq", irq1, 0);
    reset = 1'b0;
    tick();

    // Strobe-to-OBF latency and GAP length.
    drive_ps2(8'h1C);
    tick();
    check_val("lat_n1_irq", irq1, 0);
    tick();
    check_val("lat_n2_irq", irq1, 1);
    check_val("lat_n2_data", kbd_data, xlat(8'h1C));
    check_val("lat_n2_status", kbd_status, 8'h11);
    port_rd(16'h0060, rv);
    last_m = xlat(8'h1C);
    for (int i = 0; i < GAP; i++) begin
      check_val("gap_irq", irq1, 0);
      tick();
    end
    check_val("post_gap_status", kbd_status, 8'h10);

    // Extended prefix followed by a break code.
    send(8'hE0); send(8'hF0); send(8'h70);
`ifdef KBD_XT_TRANSLATE_EN
    expect_byte("seq_e0", 8'hE0);
    expect_byte("seq_brk", 8'hD2);
`else
    expect_byte("seq_e0", 8'hE0);
    expect_byte("seq_f0", 8'hF0);
    expect_byte("seq_70", 8'h70);
`endif
    pend.delete();
    drain();

    // Disable / enable.
    port_wr(16'h0064, 8'hAD);
    en_m = 1'b0;
    send(8'h1C);
    repeat (6) tick();
    check_val("dis_irq", irq1, 0);
    check_val("dis_status", kbd_status, 8'h00);
    port_wr(16'h0064, 8'hAE);
    en_m = 1'b1;
    check_val("en_status", kbd_status, 8'h10);
    send(8'h1C);
    expect_byte("en_rx", xlat(8'h1C));
    pend.delete();
    drain();

    // Flush with the output buffer held.
    send(8'h1C); send(8'h1B); send(8'h23);
    repeat (6) tick();
    port_wr(16'h0064, 8'hC0);
    expect_byte("flush_held", xlat(8'h1C));
    pend.delete();
    repeat (20) tick();
    check_val("flush_irq", irq1, 0);
    check_val("flush_status", kbd_status, 8'h10);

    // Overflow: DEPTH+2 pushes, DEPTH+1 delivered.
    for (int i = 0; i < DEPTH + 2; i++) send(pool[i % 8]);
    repeat (4) tick();
    check_val("ovr_set", kbd_status[1], drop_m);
    port_rd(16'h0064, rv);
    check_val("ovr_read_val", rv[1], 1);
    check_val("ovr_clr", kbd_status[1], 0);
    drop_m = 1'b0;
    drain();

    // Reset in FULL with entries queued.
    send(8'h1C); send(8'h1B); send(8'h23);
    repeat (6) tick();
    check_val("pre_rst_irq", irq1, 1);
    reset = 1'b1;
    tick();
    check_val("rst_full_data", kbd_data, 8'h00);
    check_val("rst_full_status", kbd_status, 8'h10);
    check_val("rst_full_irq", irq1, 0);
    reset = 1'b0;
    model_reset();
    repeat (12) tick();
    check_val("rst_fifo_empty_irq", irq1, 0);

    // Random rounds: burst of strobes, then drain everything.
    for (int r = 0; r < 8; r++) begin
      int k;
      k = $urandom_range(0, DEPTH + 3);
      for (int j = 0; j < k; j++) begin
        send(pool[$urandom_range(0, 9)]);
        repeat ($urandom_range(0, 2)) tick();
      end
      repeat (4) tick();
      check_val("rnd_ovr", kbd_status[1], drop_m);
      if (drop_m) begin
        port_rd(16'h0064, rv);
        drop_m = 1'b0;
      end
      drain();
      port_rd(16'h0060, rv);
      check_val("stale_data", rv, last_m);
      check_val("stale_irq", irq1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
